// File: rtl/function_3bit_sweep_ctrl.sv
// function_3bit_sweep_ctrl
// Built-in self-test sequencer for the 3-input function block f = x | (y & ~z).
// On an accepted start it drives {x,y,z} = 0..7 in ascending order, holds each
// vector for DWELL cycles, samples f on the last cycle of each dwell into a
// truth table (bit index {x,y,z}) and compares the table against EXPECTED.
//
// Optional feature macro: FN3_SWEEP_ERRCNT_EN adds o_err_count (popcount of
// table ^ EXPECTED). Without it the port and its logic are absent.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_start      sweep request, honoured in IDLE only
//   i_abort      synchronous cancel; beats a simultaneous start
//   i_f          function block output under test
//   o_x/o_y/o_z  registered stimulus to the function block
//   o_busy       high whenever the controller is not IDLE
//   o_done       one-cycle completion pulse
//   o_pass       table matched EXPECTED; valid from done until next start
//   o_table      captured truth table
//   o_err_count  number of mismatching table bits (macro-enabled only)
module function_3bit_sweep_ctrl #(
  parameter int unsigned DWELL    = 2,
  parameter logic [7:0]  EXPECTED = 8'hF4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_f,
  output logic       o_x,
  output logic       o_y,
  output logic       o_z,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [7:0] o_table
`ifdef FN3_SWEEP_ERRCNT_EN
  ,
  output logic [3:0] o_err_count
`endif
);

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nx;
  logic [2:0] r_idx;
  logic [7:0] r_cnt;
  logic [2:0] r_xyz;
  logic [7:0] r_table;
  logic       r_pass;

  logic       w_start_ok;
  logic       w_last;
  logic       w_clear;
  logic       w_final;
  logic [7:0] w_table_fin;

  assign w_start_ok = i_start & ~i_abort;
  assign w_last     = (r_cnt == DWELL_M1);
  // Clear results on an accepted start, or on abort anywhere outside IDLE.
  assign w_clear    = ((r_state == IDLE) & w_start_ok) | ((r_state != IDLE) & i_abort);
  // Last sample of the sweep: this edge moves RUN -> DONE.
  assign w_final    = (r_state == RUN) & ~i_abort & w_last & (r_idx == 3'd7);

  // Table including the sample being taken this cycle, so the verdict
  // computed on the RUN->DONE edge already covers the final vector.
  always_comb begin
    w_table_fin        = r_table;
    w_table_fin[r_idx] = i_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_nx = RUN;
      RUN: begin
        if (i_abort)                      w_state_nx = IDLE;
        else if (w_last && r_idx == 3'd7) w_state_nx = DONE;
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // pass is registered on entry to DONE rather than during DONE so that it
  // is already valid in the cycle done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_xyz   <= '0;
      r_table <= '0;
      r_pass  <= 1'b0;
    end else if (w_clear) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_xyz   <= '0;
      r_table <= '0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_last) begin
            r_table <= w_table_fin;
            r_cnt   <= '0;
            if (r_idx == 3'd7) begin
              r_pass <= (w_table_fin == EXPECTED);
            end else begin
              r_idx <= r_idx + 3'd1;
              r_xyz <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_xyz <= '0;
          r_idx <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef FN3_SWEEP_ERRCNT_EN
  logic [3:0] r_err_count;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < 8; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_err_count <= '0;
    else if (w_clear) r_err_count <= '0;
    else if (w_final) r_err_count <= popcnt8(w_table_fin ^ EXPECTED);
  end

  assign o_err_count = r_err_count;
`endif

  assign {o_x, o_y, o_z} = r_xyz;
  assign o_busy          = (r_state != IDLE);
  assign o_done          = (r_state == DONE);
  assign o_pass          = r_pass;
  assign o_table         = r_table;

endmodule

// File: tb/tb_function_3bit_sweep_ctrl.sv
module tb_function_3bit_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  // DWELL=2 instance
  logic start2 = 1'b0, abort2 = 1'b0, f2;
  logic x2, y2, z2, busy2, done2, pass2;
  logic [7:0] tbl2;
  logic [2:0] xyz2;
  int fm2 = 0;
  // DWELL=1 instance
  logic start1 = 1'b0, abort1 = 1'b0, f1;
  logic x1, y1, z1, busy1, done1, pass1;
  logic [7:0] tbl1;
  logic [2:0] xyz1;
  int fm1 = 0;
`ifdef FN3_SWEEP_ERRCNT_EN
  logic [3:0] err2, err1;
`endif

  // fm: 0 = real function block, 1 = stuck-at-0, 2 = stuck-at-1
  assign f2 = (fm2 == 0) ? (x2 | (y2 & ~z2)) : (fm2 == 1) ? 1'b0 : 1'b1;
  assign f1 = (fm1 == 0) ? (x1 | (y1 & ~z1)) : (fm1 == 1) ? 1'b0 : 1'b1;
  assign xyz2 = {x2, y2, z2};
  assign xyz1 = {x1, y1, z1};

  function_3bit_sweep_ctrl #(.DWELL(2), .EXPECTED(8'hF4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .i_start(start2), .i_abort(abort2), .i_f(f2),
    .o_x(x2), .o_y(y2), .o_z(z2), .o_busy(busy2), .o_done(done2),
    .o_pass(pass2), .o_table(tbl2)
`ifdef FN3_SWEEP_ERRCNT_EN
    , .o_err_count(err2)
`endif
  );

  function_3bit_sweep_ctrl #(.DWELL(1), .EXPECTED(8'hF4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .i_abort(abort1), .i_f(f1),
    .o_x(x1), .o_y(y1), .o_z(z1), .o_busy(busy1), .o_done(done1),
    .o_pass(pass1), .o_table(tbl1)
`ifdef FN3_SWEEP_ERRCNT_EN
    , .o_err_count(err1)
`endif
  );

  typedef struct {
    int         cyc;
    logic [7:0] tbl;
    logic       pass;
    logic [3:0] err;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Hand-computed results: F4 for the real block, 00/FF for stuck-at faults.
  function automatic exp_t exp_for(input int fm, input int done_cyc);
    exp_t e;
    e.cyc = done_cyc;
    case (fm)
      0:       begin e.tbl = 8'hF4; e.pass = 1'b1; e.err = 4'd0; end
      1:       begin e.tbl = 8'h00; e.pass = 1'b0; e.err = 4'd5; end
      default: begin e.tbl = 8'hFF; e.pass = 1'b0; e.err = 4'd3; end
    endcase
    return e;
  endfunction

  // Scoreboard monitors: one per instance, triggered by the done pulse.
  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      if (q2.size() == 0) chk("d2_unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q2.pop_front();
        chk("d2_done_cycle", cyc, e.cyc);
        chk("d2_table", {24'd0, tbl2}, {24'd0, e.tbl});
        chk("d2_pass", {31'd0, pass2}, {31'd0, e.pass});
`ifdef FN3_SWEEP_ERRCNT_EN
        chk("d2_err_count", {28'd0, err2}, {28'd0, e.err});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) chk("d1_unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("d1_done_cycle", cyc, e.cyc);
        chk("d1_table", {24'd0, tbl1}, {24'd0, e.tbl});
        chk("d1_pass", {31'd0, pass1}, {31'd0, e.pass});
`ifdef FN3_SWEEP_ERRCNT_EN
        chk("d1_err_count", {28'd0, err1}, {28'd0, e.err});
`endif
      end
    end
  end

  // Pulse start for one edge (E0); returns with e0 = cycle index of E0, #1 after it.
  task automatic start_sweep(input int sel, input int fm, input bit expect_done, output int e0);
    @(posedge clk); #1;
    if (sel == 2) begin fm2 = fm; start2 = 1'b1; end
    else          begin fm1 = fm; start1 = 1'b1; end
    @(posedge clk); #1;
    start2 = 1'b0;
    start1 = 1'b0;
    e0 = cyc;
    if (expect_done) begin
      if (sel == 2) q2.push_back(exp_for(fm, e0 + 16));
      else          q1.push_back(exp_for(fm, e0 + 8));
    end
  endtask

  // Wait (bounded) for busy to fall; it must fall at E0 + 8*DWELL + 1.
  task automatic wait_idle(input int sel, input int e0);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if ((sel == 2 ? busy2 : busy1) == 1'b0) seen = 1'b1;
    end
    if (!seen) chk("busy_fall_timeout", 32'd0, 32'd1);
    else chk(sel == 2 ? "d2_busy_fall_cycle" : "d1_busy_fall_cycle",
             cyc, e0 + 8 * (sel == 2 ? 2 : 1) + 1);
    chk(sel == 2 ? "d2_scoreboard_drained" : "d1_scoreboard_drained",
        sel == 2 ? q2.size() : q1.size(), 32'd0);
  endtask

  initial begin
    int e0;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    // Reset held with start high: nothing may move.
    rst_n  = 1'b0;
    start2 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("d2_reset_outputs", {19'd0, busy2, done2, pass2, xyz2, tbl2}, 32'd0);
      chk("d1_reset_outputs", {19'd0, busy1, done1, pass1, xyz1, tbl1}, 32'd0);
`ifdef FN3_SWEEP_ERRCNT_EN
      chk("d2_reset_err", {28'd0, err2}, 32'd0);
`endif
    end
    rst_n = 1'b1;
    // Start still high: the next edge is E0.
    @(posedge clk); #1;
    start2 = 1'b0;
    e0 = cyc;
    q2.push_back(exp_for(0, e0 + 16));
    chk("d2_busy_after_start", {31'd0, busy2}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk("d2_xyz_step", {29'd0, xyz2}, k);
      repeat (2) @(posedge clk);
      #1;
    end
    wait_idle(2, e0);

    // Stuck-at faults.
    start_sweep(2, 1, 1'b1, e0);
    wait_idle(2, e0);
    start_sweep(2, 2, 1'b1, e0);
    wait_idle(2, e0);

    // start re-pulsed mid-run has no effect on timing.
    start_sweep(2, 0, 1'b1, e0);
    repeat (5) @(posedge clk);
    #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    wait_idle(2, e0);

    // Abort while idx=3.
    start_sweep(2, 0, 1'b0, e0);
    repeat (6) @(posedge clk);
    #1;
    chk("d2_abort_pre_xyz", {29'd0, xyz2}, 32'd3);
    chk("d2_abort_pre_table", {24'd0, tbl2}, 32'h04);
    abort2 = 1'b1;
    @(posedge clk); #1 abort2 = 1'b0;
    chk("d2_abort_outputs", {20'd0, busy2, pass2, xyz2, tbl2}, 32'd0);
    repeat (20) @(posedge clk);

    // start and abort together in IDLE.
    #1 start2 = 1'b1; abort2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0; abort2 = 1'b0;
    chk("d2_start_abort_idle", {31'd0, busy2}, 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("d2_start_abort_idle_later", {31'd0, busy2}, 32'd0);

    // Minimum dwell.
    start_sweep(1, 0, 1'b1, e0);
    for (int k = 0; k < 8; k++) begin
      chk("d1_xyz_step", {29'd0, xyz1}, k);
      @(posedge clk); #1;
    end
    wait_idle(1, e0);

    // Asynchronous reset mid-sweep at idx=5.
    start_sweep(2, 0, 1'b0, e0);
    repeat (10) @(posedge clk);
    #1;
    chk("d2_midreset_pre_xyz", {29'd0, xyz2}, 32'd5);
    chk("d2_midreset_pre_table", {24'd0, tbl2}, 32'h14);
    #2 rst_n = 1'b0;
    #1;
    chk("d2_midreset_outputs", {19'd0, busy2, done2, pass2, xyz2, tbl2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_sweep(2, 0, 1'b1, e0);
    wait_idle(2, e0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
